// File: rtl/level_detector_pkg.sv
// Shared types and helpers for the hysteretic level detector.
package level_detector_pkg;

  typedef enum logic [1:0] {
    StLow,
    StRisePend,
    StHigh,
    StFallPend
  } state_e;

  localparam int unsigned HcWd = 8;

  // Callers sign-extend narrower samples into this width and truncate the result back.
  localparam int unsigned SmaxWd = 64;

  function automatic logic signed [SmaxWd-1:0] smax(input logic signed [SmaxWd-1:0] a,
                                                    input logic signed [SmaxWd-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/level_event_counter.sv
// Saturating event counter; a clear coinciding with an increment yields 1.
module level_event_counter #(
  parameter int unsigned CNT_WD = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [CNT_WD-1:0] cnt_o
);

  logic [CNT_WD-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_WD'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WD'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/level_detector.sv
// Hysteretic, debounced threshold detector with rise/fall strobes, rise counter and
// excursion peak capture.
module level_detector
  import level_detector_pkg::*;
#(
  parameter int unsigned DATA_WD  = 16,
  parameter int unsigned HOLD_CNT = 4,
  parameter int unsigned CNT_WD   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic signed [DATA_WD-1:0] i_data,
  input  logic signed [DATA_WD-1:0] i_thr_hi,
  input  logic signed [DATA_WD-1:0] i_thr_lo,
  input  logic                      i_clr_cnt,
  output logic                      o_level,
  output logic                      o_rise,
  output logic                      o_fall,
  output logic [CNT_WD-1:0]         o_event_cnt,
  output logic signed [DATA_WD-1:0] o_peak
);

  localparam logic signed [DATA_WD-1:0] MinVal  = {1'b1, {(DATA_WD-1){1'b0}}};
  localparam logic [HcWd-1:0]           HoldVal = HcWd'(HOLD_CNT);

  state_e                    state_q, state_d;
  logic [HcWd-1:0]           hc_q, hc_d, hc_inc;
  logic signed [DATA_WD-1:0] run_max_q, run_max_d, peak_q, peak_d, cand_max;
  logic                      level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic                      is_hi, is_lo;

  assign is_hi    = i_data > i_thr_hi;
  assign is_lo    = i_data < i_thr_lo;
  assign hc_inc   = hc_q + HcWd'(1);
  assign cand_max = DATA_WD'(smax(SmaxWd'(run_max_q), SmaxWd'(i_data)));

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    run_max_d = run_max_q;
    peak_d    = peak_q;
    level_d   = level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    unique case (state_q)
      StLow: begin
        if (is_hi) begin
          hc_d      = HcWd'(1);
          run_max_d = i_data;
          if (HoldVal == HcWd'(1)) begin
            state_d = StHigh;
            level_d = 1'b1;
            rise_d  = 1'b1;
            peak_d  = i_data;
          end else begin
            state_d = StRisePend;
          end
        end
      end
      StRisePend: begin
        if (is_hi) begin
          hc_d      = hc_inc;
          run_max_d = cand_max;
          if (hc_inc == HoldVal) begin
            state_d = StHigh;
            level_d = 1'b1;
            rise_d  = 1'b1;
            peak_d  = cand_max;
          end
        end else begin
          state_d = StLow;
          hc_d    = '0;
        end
      end
      StHigh: begin
        run_max_d = cand_max;
        if (is_lo) begin
          hc_d = HcWd'(1);
          if (HoldVal == HcWd'(1)) begin
            state_d = StLow;
            level_d = 1'b0;
            fall_d  = 1'b1;
            peak_d  = cand_max;
          end else begin
            state_d = StFallPend;
          end
        end
      end
      StFallPend: begin
        run_max_d = cand_max;
        if (is_lo) begin
          hc_d = hc_inc;
          if (hc_inc == HoldVal) begin
            state_d = StLow;
            level_d = 1'b0;
            fall_d  = 1'b1;
            peak_d  = cand_max;
          end
        end else begin
          state_d = StHigh;
          hc_d    = '0;
        end
      end
      default: begin
        state_d = StLow;
        hc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StLow;
      hc_q      <= '0;
      run_max_q <= MinVal;
      peak_q    <= MinVal;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      run_max_q <= run_max_d;
      peak_q    <= peak_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  // Counted on the same edge that raises o_rise so the count and strobe line up.
  level_event_counter #(
    .CNT_WD(CNT_WD)
  ) u_event_counter (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .inc_i(rise_d),
    .clr_i(i_clr_cnt),
    .cnt_o(o_event_cnt)
  );

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_peak  = peak_q;

endmodule

// File: doc/level_detector.md
Name: level_detector

Overview:
- Sits directly downstream of the moving-average filter and consumes its smoothed signed sample stream, one sample per clock.
- Performs hysteretic threshold detection with a consecutive-sample hold (debounce).
- Emits a level flag, single-cycle rise/fall strobes, a saturating rise-event counter, and the peak value of the most recent confirmed excursion.

Parameters:
- DATA_WD, 16, sample and threshold width (signed two's complement).
- HOLD_CNT, 4, consecutive qualifying samples needed to change level; legal range 1..255.
- CNT_WD, 16, width of the rise-event counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_data  input  DATA_WD  signed sample from the filter; valid every cycle.
- i_thr_hi  input  DATA_WD  signed rise threshold; sampled every cycle.
- i_thr_lo  input  DATA_WD  signed fall threshold; sampled every cycle.
- i_clr_cnt  input  1  synchronous clear of o_event_cnt.
- o_level  output  1  registered debounced level.
- o_rise  output  1  one-cycle strobe on a LOW->HIGH level change.
- o_fall  output  1  one-cycle strobe on a HIGH->LOW level change.
- o_event_cnt  output  CNT_WD  count of rise events; saturates at 2^CNT_WD-1.
- o_peak  output  DATA_WD  signed maximum of the last confirmed excursion.

Behaviour:
- Reset (async assert, at any time including mid-operation):
  - State = LOW, hold count = 0, o_level = 0, o_rise = 0, o_fall = 0, o_event_cnt = 0.
  - o_peak = run_max = most-negative value (-2^(DATA_WD-1)).
- Comparisons are signed and strict:
  - "hi" means i_data > i_thr_hi.
  - "lo" means i_data < i_thr_lo.
  - No internal ordering check is made on the thresholds; the rules below apply as written even if thr_lo > thr_hi.
- State machine (4 states, with a hold counter hc):
  - LOW: if hi, then hc=1 and run_max=i_data. If HOLD_CNT==1, go directly to HIGH; otherwise go to RISE_PEND. If not hi, stay in LOW.
  - RISE_PEND: if hi, then hc++ and run_max=max(run_max,i_data); when the new hc equals HOLD_CNT, go to HIGH. If not hi, go to LOW with hc=0.
  - HIGH: run_max=max(run_max,i_data). If lo, then hc=1; if HOLD_CNT==1 go directly to LOW, else go to FALL_PEND. Otherwise stay in HIGH.
  - FALL_PEND: run_max=max(run_max,i_data). If lo, then hc++; when the new hc equals HOLD_CNT, go to LOW. If not lo, go to HIGH with hc=0.
- Outputs on each confirmed transition:
  - Entering HIGH (from LOW or RISE_PEND): o_level<=1, o_rise<=1 for exactly one cycle, o_peak<=max(run_max,i_data).
  - Entering LOW (from HIGH or FALL_PEND): o_level<=0, o_fall<=1 for exactly one cycle, o_peak<=max(run_max,i_data).
- Latency: if the first qualifying sample is captured at edge k, o_level and the strobe become visible after edge k+HOLD_CNT-1.
- Hysteresis: samples in [thr_lo, thr_hi] never change state from HIGH or LOW. They do abort any pending transition.
- o_peak:
  - Changes only on confirmed transitions; holds otherwise.
  - An aborted RISE_PEND does not affect o_peak.
- o_event_cnt:
  - +1 on each o_rise; saturates (no wrap).
  - i_clr_cnt alone clears it to 0.
  - i_clr_cnt together with a rise in the same cycle gives 1.
- o_rise and o_fall are never high in the same cycle.
- The threshold inputs may change at any time; the new values take effect on the next edge.

Decomposition:
- Package level_detector_pkg:
  - typedef enum logic [1:0] for the states: LOW, RISE_PEND, HIGH, FALL_PEND.
  - Localparam for the hold counter width (8 bits).
  - Function smax(a,b) for the signed maximum.
- Sub-module level_event_counter: saturating CNT_WD counter with inc and clr inputs, clear-plus-increment yielding 1.
- All remaining logic (FSM, hold counter, peak tracking) stays in the top module.

Test Plan:
- Parameters for all cases: HOLD_CNT=3, thr_hi=100, thr_lo=50, DATA_WD=16.
- Reset: drive the stream to HIGH, then assert i_rst asynchronously between edges -> all outputs clear immediately, o_peak=-32768, and the next samples 0,120 give no rise.
- Rise: data 0,120,130,110 -> o_rise=1 for one cycle after the edge capturing 110; o_level=1; o_event_cnt=1; o_peak=130.
- Glitch rejection: data 120,130,0,120,0 -> o_level stays 0, no strobe, o_event_cnt=0, o_peak unchanged.
- Hysteresis and fall:
  - From HIGH, data 70,90,40,60,40,30,20 -> no change through 60.
  - The fall run completes at 20: o_fall one cycle, o_level=0.
- Counter:
  - With CNT_WD=2, produce 5 rises -> o_event_cnt 1,2,3,3,3.
  - Assert i_clr_cnt in the same cycle as a rise -> o_event_cnt=1.
- Signed thresholds: thr_hi=-10, thr_lo=-50; data -60,-5,-5,-5 -> rise with o_peak=-5; then -9 holds HIGH; then -51 three times -> fall.
